// File: rtl/lieat_idu_oitf_pkg.sv
// lieat_idu_oitf_pkg: shared types and constants for the outstanding instruction track FIFO
package lieat_idu_oitf_pkg;
    localparam int REG_IDX_W  = 5;
    localparam int OITF_DEPTH = 4;

    typedef struct packed {
        logic                 vld;
        logic [REG_IDX_W-1:0] rd_idx;
        logic                 rd_wen;
    } oitf_entry_t;
endpackage

// File: rtl/lieat_dfflr.sv
// lieat_dfflr: load-enabled flop with asynchronous active-low reset to zero
//   clk_i  : clock
//   rst_ni : async reset, active low
//   en_i   : load enable
//   d_i    : next value
//   q_o    : registered value
module lieat_dfflr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            q_o <= '0;
        else if (en_i)
            q_o <= d_i;
    end
endmodule

// File: rtl/lieat_oitf_dep_cmp.sv
// lieat_oitf_dep_cmp: matches one register index against every outstanding OITF rd
//   idx_i    : register index under test
//   en_i     : index is actually used by the instruction
//   vld_i    : per-entry valid
//   wen_i    : per-entry rd-write flag
//   rd_idx_i : per-entry rd, entry k at bits [k*5 +: 5]
//   hit_o    : at least one live entry writes this index
module lieat_oitf_dep_cmp
    import lieat_idu_oitf_pkg::*;
#(
    parameter int DEPTH = OITF_DEPTH
) (
    input  logic [REG_IDX_W-1:0]       idx_i,
    input  logic                       en_i,
    input  logic [DEPTH-1:0]           vld_i,
    input  logic [DEPTH-1:0]           wen_i,
    input  logic [DEPTH*REG_IDX_W-1:0] rd_idx_i,
    output logic                       hit_o
);
    logic [DEPTH-1:0] match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = vld_i[i] & wen_i[i] & (rd_idx_i[i*REG_IDX_W +: REG_IDX_W] == idx_i);
    end

    // x0 is hardwired to zero and can never carry a hazard
    assign hit_o = en_i & (idx_i != '0) & (|match);
endmodule

// File: rtl/lieat_idu_oitf.sv
// lieat_idu_oitf: outstanding instruction track FIFO with RAW/WAW hazard detection
//   clock, reset            : clock, async active-low reset
//   disp_ena/_rd_idx/_rd_wen: allocate a long-latency instruction and its rd
//   dec_rs1/rs2/rd_*        : operands of the instruction at dispatch
//   ret_ena                 : retire the oldest entry
//   alloc_ptr, ret_ptr      : next allocation slot, oldest slot
//   ret_rd_idx/_wen         : rd info of the oldest entry
//   oitf_full, oitf_empty   : occupancy flags from registered pointers only
//   raw_dep, waw_dep        : hazards against outstanding entries
module lieat_idu_oitf
    import lieat_idu_oitf_pkg::*;
#(
    parameter int DEPTH = OITF_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 disp_ena,
    input  logic [REG_IDX_W-1:0] disp_rd_idx,
    input  logic                 disp_rd_wen,
    input  logic [REG_IDX_W-1:0] dec_rs1_idx,
    input  logic                 dec_rs1_en,
    input  logic [REG_IDX_W-1:0] dec_rs2_idx,
    input  logic                 dec_rs2_en,
    input  logic [REG_IDX_W-1:0] dec_rd_idx,
    input  logic                 dec_rd_wen,
    input  logic                 ret_ena,
    output logic [PTR_W-1:0]     alloc_ptr,
    output logic [PTR_W-1:0]     ret_ptr,
    output logic [REG_IDX_W-1:0] ret_rd_idx,
    output logic                 ret_rd_wen,
    output logic                 oitf_full,
    output logic                 oitf_empty,
    output logic                 raw_dep,
    output logic                 waw_dep
);
    localparam int ENT_W = $bits(oitf_entry_t);

    logic [PTR_W:0]                 alloc_ptr_q, alloc_ptr_d, ret_ptr_q, ret_ptr_d;
    logic                           alloc_fire, ret_fire;
    oitf_entry_t [DEPTH-1:0]        ent_q;
    logic [DEPTH-1:0]               vld, wen;
    logic [DEPTH-1:0][REG_IDX_W-1:0] idx;
    logic                           rs1_hit, rs2_hit, rd_hit;

    // MSB of each pointer is a wrap flag distinguishing full from empty
    assign oitf_empty = alloc_ptr_q == ret_ptr_q;
    assign oitf_full  = (alloc_ptr_q[PTR_W-1:0] == ret_ptr_q[PTR_W-1:0]) &&
                        (alloc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);

    // Gating uses registered flags, so a same-cycle retire never frees a slot
    // for a same-cycle allocate, nor the reverse
    assign alloc_fire  = disp_ena & ~oitf_full;
    assign ret_fire    = ret_ena & ~oitf_empty;
    assign alloc_ptr_d = alloc_ptr_q + (PTR_W+1)'(1);
    assign ret_ptr_d   = ret_ptr_q + (PTR_W+1)'(1);

    lieat_dfflr #(.W(PTR_W+1)) u_alloc_ptr (
        .clk_i (clock),
        .rst_ni(reset),
        .en_i  (alloc_fire),
        .d_i   (alloc_ptr_d),
        .q_o   (alloc_ptr_q)
    );

    lieat_dfflr #(.W(PTR_W+1)) u_ret_ptr (
        .clk_i (clock),
        .rst_ni(reset),
        .en_i  (ret_fire),
        .d_i   (ret_ptr_d),
        .q_o   (ret_ptr_q)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic        set, clr;
        oitf_entry_t ent_d;
        // set and clr cannot hit one slot together: equal low pointer bits
        // mean empty (no retire) or full (no allocate)
        assign set   = alloc_fire && (alloc_ptr_q[PTR_W-1:0] == PTR_W'(i));
        assign clr   = ret_fire && (ret_ptr_q[PTR_W-1:0] == PTR_W'(i));
        assign ent_d = set ? '{vld: 1'b1, rd_idx: disp_rd_idx, rd_wen: disp_rd_wen}
                           : '{vld: 1'b0, rd_idx: ent_q[i].rd_idx, rd_wen: ent_q[i].rd_wen};
        lieat_dfflr #(.W(ENT_W)) u_ent (
            .clk_i (clock),
            .rst_ni(reset),
            .en_i  (set | clr),
            .d_i   (ent_d),
            .q_o   (ent_q[i])
        );
        assign vld[i] = ent_q[i].vld;
        assign wen[i] = ent_q[i].rd_wen;
        assign idx[i] = ent_q[i].rd_idx;
    end

    lieat_oitf_dep_cmp #(.DEPTH(DEPTH)) u_cmp_rs1 (
        .idx_i   (dec_rs1_idx),
        .en_i    (dec_rs1_en),
        .vld_i   (vld),
        .wen_i   (wen),
        .rd_idx_i(idx),
        .hit_o   (rs1_hit)
    );

    lieat_oitf_dep_cmp #(.DEPTH(DEPTH)) u_cmp_rs2 (
        .idx_i   (dec_rs2_idx),
        .en_i    (dec_rs2_en),
        .vld_i   (vld),
        .wen_i   (wen),
        .rd_idx_i(idx),
        .hit_o   (rs2_hit)
    );

    lieat_oitf_dep_cmp #(.DEPTH(DEPTH)) u_cmp_rd (
        .idx_i   (dec_rd_idx),
        .en_i    (dec_rd_wen),
        .vld_i   (vld),
        .wen_i   (wen),
        .rd_idx_i(idx),
        .hit_o   (rd_hit)
    );

    assign raw_dep    = rs1_hit | rs2_hit;
    assign waw_dep    = rd_hit;
    assign alloc_ptr  = alloc_ptr_q[PTR_W-1:0];
    assign ret_ptr    = ret_ptr_q[PTR_W-1:0];
    assign ret_rd_idx = ent_q[ret_ptr].rd_idx;
    assign ret_rd_wen = ent_q[ret_ptr].rd_wen;

    // Protocol errors are dropped by the gating above; flag them in simulation
    a_no_alloc_full: assert property (@(posedge clock) disable iff (!reset) !(disp_ena && oitf_full))
        else $warning("oitf: dispatch while full ignored");
    a_no_ret_empty: assert property (@(posedge clock) disable iff (!reset) !(ret_ena && oitf_empty))
        else $warning("oitf: retire while empty ignored");
endmodule

// File: tb/tb_lieat_idu_oitf.sv
// tb_lieat_idu_oitf: scoreboard-driven self-checking bench for lieat_idu_oitf
module tb_lieat_idu_oitf;
    logic       clock = 1'b0, reset = 1'b0;
    logic       disp_ena = 1'b0, disp_rd_wen = 1'b0, ret_ena = 1'b0;
    logic [4:0] disp_rd_idx = '0;
    logic [4:0] dec_rs1_idx = '0, dec_rs2_idx = '0, dec_rd_idx = '0;
    logic       dec_rs1_en = 1'b0, dec_rs2_en = 1'b0, dec_rd_wen = 1'b0;
    logic [1:0] alloc_ptr, ret_ptr;
    logic [4:0] ret_rd_idx;
    logic       ret_rd_wen, oitf_full, oitf_empty, raw_dep, waw_dep;

    int total = 0, bad = 0;
    logic [5:0] sb[$];
    int m_alloc = 0, m_ret = 0;

    lieat_idu_oitf dut (
        .clock      (clock),
        .reset      (reset),
        .disp_ena   (disp_ena),
        .disp_rd_idx(disp_rd_idx),
        .disp_rd_wen(disp_rd_wen),
        .dec_rs1_idx(dec_rs1_idx),
        .dec_rs1_en (dec_rs1_en),
        .dec_rs2_idx(dec_rs2_idx),
        .dec_rs2_en (dec_rs2_en),
        .dec_rd_idx (dec_rd_idx),
        .dec_rd_wen (dec_rd_wen),
        .ret_ena    (ret_ena),
        .alloc_ptr  (alloc_ptr),
        .ret_ptr    (ret_ptr),
        .ret_rd_idx (ret_rd_idx),
        .ret_rd_wen (ret_rd_wen),
        .oitf_full  (oitf_full),
        .oitf_empty (oitf_empty),
        .raw_dep    (raw_dep),
        .waw_dep    (waw_dep)
    );

    always #5 clock = ~clock;

    task automatic idle();
        disp_ena = 0; ret_ena = 0; disp_rd_idx = 0; disp_rd_wen = 0;
        dec_rs1_idx = 0; dec_rs1_en = 0; dec_rs2_idx = 0; dec_rs2_en = 0;
        dec_rd_idx = 0; dec_rd_wen = 0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;
        sb.delete(); m_alloc = 0; m_ret = 0;
    endtask

    // Drives one cycle of allocate and/or retire; the model applies the same
    // pre-edge full/empty gating a correct OITF must
    task automatic cycle_op(input logic a, input logic r, input logic [4:0] idx, input logic w);
        bit do_a, do_r;
        do_a = a && sb.size() < 4;
        do_r = r && sb.size() > 0;
        disp_ena = a; disp_rd_idx = idx; disp_rd_wen = w; ret_ena = r;
        @(posedge clock);
        #1 disp_ena = 0; ret_ena = 0;
        if (do_r) begin void'(sb.pop_front()); m_ret++; end
        if (do_a) begin sb.push_back({idx, w}); m_alloc++; end
    endtask

    task automatic test_reset();
        reset = 0; idle();
        repeat (3) @(posedge clock);
        #1 reset = 1;
        #1;
        total++;
        if ({oitf_empty, oitf_full, alloc_ptr, ret_ptr, raw_dep, waw_dep, ret_rd_idx, ret_rd_wen} !== 14'b10_0000_00_00000_0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=%b", {oitf_empty, oitf_full, alloc_ptr, ret_ptr, raw_dep, waw_dep, ret_rd_idx, ret_rd_wen}, 14'b10_0000_00_00000_0);
        end
    endtask

    task automatic test_raw();
        apply_reset();
        cycle_op(1, 0, 5'd5, 1);
        dec_rs1_idx = 5; dec_rs1_en = 1;
        #1; total++;
        if (raw_dep !== 1'b1) begin bad++; $display("FAIL raw_rs1 got=%b exp=1", raw_dep); end
        dec_rs1_en = 0; dec_rs2_idx = 5; dec_rs2_en = 1;
        #1; total++;
        if (raw_dep !== 1'b1) begin bad++; $display("FAIL raw_rs2 got=%b exp=1", raw_dep); end
        total++;
        if ({ret_rd_idx, ret_rd_wen} !== sb[0]) begin bad++; $display("FAIL raw_ret_rd got=%h exp=%h", {ret_rd_idx, ret_rd_wen}, sb[0]); end
        ret_ena = 1;
        #1; total++;
        if (raw_dep !== 1'b1) begin bad++; $display("FAIL raw_retire_cycle got=%b exp=1", raw_dep); end
        cycle_op(0, 1, 5'd0, 0);
        total++;
        if ({raw_dep, oitf_empty, ret_ptr} !== {1'b0, 1'b1, 2'(m_ret)}) begin
            bad++; $display("FAIL raw_after_retire got=%b exp=%b", {raw_dep, oitf_empty, ret_ptr}, {1'b0, 1'b1, 2'(m_ret)});
        end
        idle();
    endtask

    task automatic test_fill_wrap();
        apply_reset();
        for (int i = 1; i <= 4; i++) cycle_op(1, 0, 5'(i), 1);
        total++;
        if ({oitf_full, oitf_empty, alloc_ptr, ret_ptr} !== 6'b10_00_00) begin
            bad++; $display("FAIL fill_full got=%b exp=100000", {oitf_full, oitf_empty, alloc_ptr, ret_ptr});
        end
        dec_rd_wen = 1;
        for (int i = 1; i <= 4; i++) begin
            dec_rd_idx = 5'(i);
            #1; total++;
            if (waw_dep !== 1'b1) begin bad++; $display("FAIL fill_waw rd=%0d got=%b exp=1", i, waw_dep); end
        end
        dec_rd_idx = 9;
        #1; total++;
        if (waw_dep !== 1'b0) begin bad++; $display("FAIL fill_waw_miss got=%b exp=0", waw_dep); end
        idle();
        cycle_op(0, 1, 5'd0, 0);
        total++;
        if ({oitf_full, ret_ptr, ret_rd_idx, ret_rd_wen} !== {1'b0, 2'd1, sb[0]}) begin
            bad++; $display("FAIL wrap_retire got=%b exp=%b", {oitf_full, ret_ptr, ret_rd_idx, ret_rd_wen}, {1'b0, 2'd1, sb[0]});
        end
        cycle_op(1, 0, 5'd10, 1);
        total++;
        if ({oitf_full, alloc_ptr, ret_ptr} !== 5'b1_01_01) begin
            bad++; $display("FAIL wrap_refill got=%b exp=10101", {oitf_full, alloc_ptr, ret_ptr});
        end
        cycle_op(1, 1, 5'd11, 1);
        total++;
        if ({oitf_full, alloc_ptr, ret_ptr} !== {1'b0, 2'(m_alloc), 2'(m_ret)} || m_alloc != 5) begin
            bad++; $display("FAIL full_both got=%b exp=%b", {oitf_full, alloc_ptr, ret_ptr}, {1'b0, 2'(m_alloc), 2'(m_ret)});
        end
        while (sb.size() > 0) begin
            total++;
            if ({ret_rd_idx, ret_rd_wen} !== sb[0]) begin bad++; $display("FAIL drain_rd got=%h exp=%h", {ret_rd_idx, ret_rd_wen}, sb[0]); end
            cycle_op(0, 1, 5'd0, 0);
        end
        total++;
        if (oitf_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", oitf_empty); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cycle_op(1, 0, 5'd3, 1);
        cycle_op(1, 0, 5'd6, 1);
        cycle_op(1, 1, 5'd8, 1);
        total++;
        if ({oitf_full, oitf_empty, alloc_ptr, ret_ptr, ret_rd_idx, ret_rd_wen} !== {2'b00, 2'd3, 2'd1, sb[0]} || sb.size() != 2) begin
            bad++; $display("FAIL simul_ptrs got=%b exp=%b", {oitf_full, oitf_empty, alloc_ptr, ret_ptr, ret_rd_idx, ret_rd_wen}, {2'b00, 2'd3, 2'd1, sb[0]});
        end
        dec_rd_wen = 1; dec_rd_idx = 8;
        #1; total++;
        if (waw_dep !== 1'b1) begin bad++; $display("FAIL simul_waw_new got=%b exp=1", waw_dep); end
        dec_rd_idx = 3;
        #1; total++;
        if (waw_dep !== 1'b0) begin bad++; $display("FAIL simul_waw_old got=%b exp=0", waw_dep); end
        idle();
        cycle_op(0, 1, 5'd0, 0);
        cycle_op(0, 1, 5'd0, 0);
        cycle_op(1, 1, 5'd9, 1);
        total++;
        if ({oitf_empty, alloc_ptr, ret_ptr, ret_rd_idx, ret_rd_wen} !== {1'b0, 2'(m_alloc), 2'(m_ret), 6'b01001_1} || m_ret != 3) begin
            bad++; $display("FAIL empty_both got=%b exp=%b", {oitf_empty, alloc_ptr, ret_ptr, ret_rd_idx, ret_rd_wen}, {1'b0, 2'(m_alloc), 2'(m_ret), 6'b01001_1});
        end
    endtask

    task automatic test_x0();
        apply_reset();
        cycle_op(1, 0, 5'd0, 1);
        dec_rs1_idx = 0; dec_rs1_en = 1; dec_rd_idx = 0; dec_rd_wen = 1;
        #1; total++;
        if ({raw_dep, waw_dep} !== 2'b00) begin bad++; $display("FAIL x0_dep got=%b exp=00", {raw_dep, waw_dep}); end
        idle();
        cycle_op(1, 0, 5'd7, 0);
        dec_rd_idx = 7; dec_rd_wen = 1; dec_rs2_idx = 7; dec_rs2_en = 1;
        #1; total++;
        if ({raw_dep, waw_dep} !== 2'b00) begin bad++; $display("FAIL nowen_dep got=%b exp=00", {raw_dep, waw_dep}); end
        idle();
        cycle_op(1, 0, 5'd12, 1);
        dec_rs2_idx = 12; dec_rs2_en = 1;
        #1; total++;
        if (raw_dep !== 1'b1) begin bad++; $display("FAIL rs2_hit got=%b exp=1", raw_dep); end
        dec_rs2_en = 0;
        #1; total++;
        if (raw_dep !== 1'b0) begin bad++; $display("FAIL rs2_disabled got=%b exp=0", raw_dep); end
        idle();
    endtask

    task automatic test_illegal();
        apply_reset();
        cycle_op(0, 1, 5'd0, 0);
        total++;
        if ({oitf_empty, alloc_ptr, ret_ptr} !== 5'b1_00_00) begin
            bad++; $display("FAIL ret_empty got=%b exp=10000", {oitf_empty, alloc_ptr, ret_ptr});
        end
        for (int i = 20; i < 24; i++) cycle_op(1, 0, 5'(i), 1);
        cycle_op(1, 0, 5'd30, 1);
        total++;
        if ({oitf_full, alloc_ptr, ret_ptr} !== 5'b1_00_00) begin
            bad++; $display("FAIL disp_full got=%b exp=10000", {oitf_full, alloc_ptr, ret_ptr});
        end
        dec_rd_idx = 30; dec_rd_wen = 1;
        #1; total++;
        if (waw_dep !== 1'b0) begin bad++; $display("FAIL disp_full_waw got=%b exp=0", waw_dep); end
        idle();
        while (sb.size() > 0) begin
            total++;
            if ({ret_rd_idx, ret_rd_wen} !== sb[0]) begin bad++; $display("FAIL illegal_drain got=%h exp=%h", {ret_rd_idx, ret_rd_wen}, sb[0]); end
            cycle_op(0, 1, 5'd0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_fill_wrap();
        test_back_to_back();
        test_x0();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
